// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  // Memory request direction
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Access size codes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access FSM: one request per instruction, then a release state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // True when the EX_MEM instruction is a load.
  function automatic logic is_load(input logic wr_enable, input logic wr);
    return wr_enable & (wr == MEM_READ);
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of right-aligned load data, selected by load funct3.
module mem_stage_load_extend
  import mem_stage_pkg::*;
#(
  parameter int REG_LEN = 32
) (
  input  logic [2:0]         funct3,
  input  logic [REG_LEN-1:0] raw_data,
  output logic [REG_LEN-1:0] ext_data
);

  // Pick the extension rule from funct3; unknown codes yield zero.
  always_comb begin
    ext_data = {REG_LEN{1'b0}};
    case (funct3)
      F3_LB:   ext_data = {{(REG_LEN-8){raw_data[7]}}, raw_data[7:0]};
      F3_LH:   ext_data = {{(REG_LEN-16){raw_data[15]}}, raw_data[15:0]};
      F3_LW:   ext_data = raw_data;
      F3_LBU:  ext_data = {{(REG_LEN-8){1'b0}}, raw_data[7:0]};
      F3_LHU:  ext_data = {{(REG_LEN-16){1'b0}}, raw_data[15:0]};
      default: ext_data = {REG_LEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues one memory request per load/store, stalls until the
// controller reports completion, then forwards extended load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int REG_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                in_wr_enable,
  input  logic                in_wr,
  input  logic [2:0]          in_funct3,
  input  logic [1:0]          in_type,
  input  logic [ADDR_LEN-1:0] in_addr,
  input  logic [REG_LEN-1:0]  in_store_data,
  input  logic [4:0]          in_rd_addr,
  input  logic                in_rd_write_enable,
  input  logic [REG_LEN-1:0]  in_rd_data,
  output logic                mc_req,
  output logic                mc_wr,
  output logic [1:0]          mc_type,
  output logic [ADDR_LEN-1:0] mc_addr,
  output logic [REG_LEN-1:0]  mc_wdata,
  input  logic                mc_done,
  input  logic [REG_LEN-1:0]  mc_rdata,
  output logic [REG_LEN-1:0]  out_rd_data,
  output logic [4:0]          out_rd_addr,
  output logic                out_rd_write_enable,
  output logic                stall_req
);

  mem_state_e          state_q, state_d;
  logic                mc_req_q, mc_req_d;
  logic                mc_wr_q, mc_wr_d;
  logic [1:0]          mc_type_q, mc_type_d;
  logic [ADDR_LEN-1:0] mc_addr_q, mc_addr_d;
  logic [REG_LEN-1:0]  mc_wdata_q, mc_wdata_d;
  logic [REG_LEN-1:0]  load_data_q, load_data_d;
  logic [REG_LEN-1:0]  ext_data_s;

  // EX_MEM holds the instruction stable while stalled, so funct3 is valid at mc_done.
  mem_stage_load_extend #(.REG_LEN(REG_LEN)) u_load_extend (
    .funct3   (in_funct3),
    .raw_data (mc_rdata),
    .ext_data (ext_data_s)
  );

  // State and request registers; synchronous active-low reset beats mc_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mc_req_q    <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_type_q   <= 2'b00;
      mc_addr_q   <= {ADDR_LEN{1'b0}};
      mc_wdata_q  <= {REG_LEN{1'b0}};
      load_data_q <= {REG_LEN{1'b0}};
    end else begin
      state_q     <= state_d;
      mc_req_q    <= mc_req_d;
      mc_wr_q     <= mc_wr_d;
      mc_type_q   <= mc_type_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // Next-state: launch in IDLE, wait for mc_done regardless of rdy, release in DONE.
  always_comb begin
    state_d     = state_q;
    mc_req_d    = mc_req_q;
    mc_wr_d     = mc_wr_q;
    mc_type_d   = mc_type_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_wr_enable && rdy) begin
          state_d    = ST_WAIT;
          mc_req_d   = 1'b1;
          mc_wr_d    = in_wr;
          mc_type_d  = in_type;
          mc_addr_d  = in_addr;
          mc_wdata_d = in_store_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mc_done) begin
          state_d     = ST_DONE;
          mc_req_d    = 1'b0;
          load_data_d = ext_data_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mc_req_d = 1'b0;
      end
    endcase
  end

  // Stall and writeback mux; loads only write back once the data is captured.
  always_comb begin
    stall_req           = 1'b0;
    out_rd_data         = in_rd_data;
    out_rd_addr         = in_rd_addr;
    out_rd_write_enable = in_rd_write_enable;
    case (state_q)
      ST_IDLE: stall_req = in_wr_enable;
      ST_WAIT: stall_req = 1'b1;
      ST_DONE: stall_req = 1'b0;
      default: stall_req = 1'b0;
    endcase
    if (is_load(in_wr_enable, in_wr)) begin
      if (state_q == ST_DONE) begin
        out_rd_data = load_data_q;
      end else begin
        out_rd_data         = {REG_LEN{1'b0}};
        out_rd_write_enable = 1'b0;
      end
    end else begin
      out_rd_data = in_rd_data;
    end
  end

  assign mc_req   = mc_req_q;
  assign mc_wr    = mc_wr_q;
  assign mc_type  = mc_type_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus multi-cycle sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_wr_enable, in_wr;
  logic [2:0]  in_funct3;
  logic [1:0]  in_type;
  logic [31:0] in_addr, in_store_data, in_rd_data;
  logic [4:0]  in_rd_addr;
  logic        in_rd_write_enable;
  logic        mc_req, mc_wr;
  logic [1:0]  mc_type;
  logic [31:0] mc_addr, mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;
  logic [31:0] out_rd_data;
  logic [4:0]  out_rd_addr;
  logic        out_rd_write_enable;
  logic        stall_req;

  mem_stage #(.ADDR_LEN(32), .REG_LEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_wr_enable(in_wr_enable), .in_wr(in_wr), .in_funct3(in_funct3),
    .in_type(in_type), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_rd_addr(in_rd_addr), .in_rd_write_enable(in_rd_write_enable),
    .in_rd_data(in_rd_data),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_type(mc_type), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
    .out_rd_data(out_rd_data), .out_rd_addr(out_rd_addr),
    .out_rd_write_enable(out_rd_write_enable), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wr;
    logic [2:0]  f3;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] sb_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          req_rises = 0;
  int          req_cycles = 0;
  logic        req_prev = 1'b0;

  // Count request rising edges and request-high cycles.
  always @(negedge clk) begin
    if (mc_req) req_cycles++;
    if (mc_req && !req_prev) req_rises++;
    req_prev = mc_req;
  end

  function automatic vec_t mk(logic en, logic wr, logic [2:0] f3, logic [1:0] typ,
                              logic [31:0] addr, logic [31:0] sdata, logic [4:0] rd,
                              logic rd_we, logic [31:0] rd_data, logic [31:0] rdata,
                              logic [31:0] exp_data, logic exp_we);
    vec_t v;
    v.en = en; v.wr = wr; v.f3 = f3; v.typ = typ; v.addr = addr; v.sdata = sdata;
    v.rd = rd; v.rd_we = rd_we; v.rd_data = rd_data; v.rdata = rdata;
    v.exp_data = exp_data; v.exp_we = exp_we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_wr_enable = v.en; in_wr = v.wr; in_funct3 = v.f3; in_type = v.typ;
    in_addr = v.addr; in_store_data = v.sdata; in_rd_addr = v.rd;
    in_rd_write_enable = v.rd_we; in_rd_data = v.rd_data;
  endtask

  task automatic clear_in();
    in_wr_enable = 1'b0; in_wr = 1'b0; in_funct3 = 3'b000; in_type = 2'b00;
    in_addr = 32'h0; in_store_data = 32'h0; in_rd_addr = 5'd0;
    in_rd_write_enable = 1'b0; in_rd_data = 32'h0;
  endtask

  // Non-memory instruction: zero-latency passthrough, no stall, no request.
  task automatic do_pass(input vec_t v);
    drive(v);
    sb_q.push_back(v.exp_data);
    @(negedge clk);
    chk("pass_stall", {31'd0, stall_req}, 32'd0);
    chk("pass_data", out_rd_data, sb_q.pop_front());
    chk("pass_addr", {27'd0, out_rd_addr}, {27'd0, v.rd});
    chk("pass_we", {31'd0, out_rd_write_enable}, {31'd0, v.exp_we});
    @(posedge clk); #1;
    chk("pass_noreq", {31'd0, mc_req}, 32'd0);
  endtask

  // Load/store: the memory controller answers lat cycles after the request rises.
  task automatic do_access(input vec_t v, input int lat);
    int r0, c0;
    r0 = req_rises; c0 = req_cycles;
    drive(v);
    sb_q.push_back(v.exp_data);
    @(negedge clk);
    chk("acc_stall_pre", {31'd0, stall_req}, 32'd1);
    chk("acc_req_pre", {31'd0, mc_req}, 32'd0);
    chk("acc_we_pre", {31'd0, out_rd_write_enable}, v.wr ? {31'd0, v.rd_we} : 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("acc_req", {31'd0, mc_req}, 32'd1);
    chk("acc_wr", {31'd0, mc_wr}, {31'd0, v.wr});
    chk("acc_type", {30'd0, mc_type}, {30'd0, v.typ});
    chk("acc_addr", mc_addr, v.addr);
    if (v.wr) chk("acc_wdata", mc_wdata, v.sdata);
    else chk("acc_ld_we_wait", {31'd0, out_rd_write_enable}, 32'd0);
    repeat (lat - 1) @(posedge clk);
    #1; mc_done = 1'b1; mc_rdata = v.rdata;
    @(posedge clk); #1;
    mc_done = 1'b0; mc_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("acc_stall_done", {31'd0, stall_req}, 32'd0);
    chk("acc_req_done", {31'd0, mc_req}, 32'd0);
    chk("acc_data", out_rd_data, sb_q.pop_front());
    chk("acc_rd_addr", {27'd0, out_rd_addr}, {27'd0, v.rd});
    chk("acc_we", {31'd0, out_rd_write_enable}, {31'd0, v.exp_we});
    @(posedge clk); #1;
    clear_in();
    chk("acc_one_req", req_rises - r0, 32'd1);
    chk("acc_req_cycles", req_cycles - c0, lat);
  endtask

  initial begin
    int r0;
    vecs[0]  = mk(1'b1, 1'b0, 3'b000, 2'b00, 32'h100,  32'h0, 5'd10, 1'b1, 32'h100,  32'h0000_0080, 32'hFFFF_FF80, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 3'b100, 2'b00, 32'h101,  32'h0, 5'd11, 1'b1, 32'h101,  32'h0000_0080, 32'h0000_0080, 1'b1);
    vecs[2]  = mk(1'b1, 1'b0, 3'b001, 2'b01, 32'h102,  32'h0, 5'd12, 1'b1, 32'h102,  32'h0000_8001, 32'hFFFF_8001, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 3'b101, 2'b01, 32'h104,  32'h0, 5'd13, 1'b1, 32'h104,  32'h0000_8001, 32'h0000_8001, 1'b1);
    vecs[4]  = mk(1'b1, 1'b0, 3'b010, 2'b10, 32'h108,  32'h0, 5'd14, 1'b1, 32'h108,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 3'b000, 2'b00, 32'h10C,  32'h0, 5'd15, 1'b1, 32'h10C,  32'hABCD_EF7F, 32'h0000_007F, 1'b1);
    vecs[6]  = mk(1'b1, 1'b0, 3'b101, 2'b01, 32'h110,  32'h0, 5'd16, 1'b1, 32'h110,  32'hFFFF_1234, 32'h0000_1234, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 3'b011, 2'b10, 32'h114,  32'h0, 5'd17, 1'b1, 32'h114,  32'h1234_5678, 32'h0000_0000, 1'b1);
    vecs[8]  = mk(1'b1, 1'b1, 3'b010, 2'b10, 32'h1000, 32'h1234_5678, 5'd0, 1'b0, 32'h1000, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 3'b000, 2'b00, 32'h0,    32'h0, 5'd5,  1'b1, 32'h55,   32'h0, 32'h0000_0055, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 3'b000, 2'b00, 32'h2003, 32'h0000_00AB, 5'd0, 1'b0, 32'h2003, 32'h0, 32'h0000_2003, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 3'b000, 2'b00, 32'h0,    32'h0, 5'd7,  1'b0, 32'h77,   32'h0, 32'h0000_0077, 1'b0);

    rst = 1'b0; rdy = 1'b1; mc_done = 1'b0; mc_rdata = 32'h0;
    clear_in();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'd0, mc_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_data", out_rd_data, 32'd0);
    chk("rst_we", {31'd0, out_rd_write_enable}, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].en) do_access(vecs[i], 4);
      else do_pass(vecs[i]);
    end

    // mc_done while idle is ignored.
    mc_done = 1'b1; mc_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mc_done = 1'b0;
    @(negedge clk);
    chk("stray_done_req", {31'd0, mc_req}, 32'd0);
    chk("stray_done_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;

    // rdy low in IDLE: stall asserted, no request issued until rdy returns.
    drive(vecs[4]);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy0_stall", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy0_noreq", {31'd0, mc_req}, 32'd0);
    chk("rdy0_stall2", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    rdy = 1'b1;
    do_access(vecs[4], 2);

    // Two back-to-back loads; rdy low during DONE holds DONE without re-issuing.
    r0 = req_rises;
    drive(vecs[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mc_done = 1'b1; mc_rdata = 32'h0000_0080;
    @(posedge clk); #1;
    mc_done = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    chk("hold_data1", out_rd_data, 32'hFFFF_FF80);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_data2", out_rd_data, 32'hFFFF_FF80);
    chk("hold_we", {31'd0, out_rd_write_enable}, 32'd1);
    chk("hold_stall", {31'd0, stall_req}, 32'd0);
    chk("hold_noreq", {31'd0, mc_req}, 32'd0);
    rdy = 1'b1;
    @(posedge clk); #1;
    drive(vecs[2]);
    @(negedge clk);
    chk("b2b_stall", {31'd0, stall_req}, 32'd1);
    chk("b2b_we_idle", {31'd0, out_rd_write_enable}, 32'd0);
    @(posedge clk); #1;
    mc_done = 1'b1; mc_rdata = 32'h0000_8001;
    @(posedge clk); #1;
    mc_done = 1'b0;
    @(negedge clk);
    chk("b2b_data2", out_rd_data, 32'hFFFF_8001);
    @(posedge clk); #1;
    clear_in();
    chk("b2b_two_reqs", req_rises - r0, 32'd2);

    // Reset during WAIT with a coincident mc_done: reset wins.
    drive(vecs[4]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_req_pre", {31'd0, mc_req}, 32'd1);
    rst = 1'b0; mc_done = 1'b1; mc_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mc_done = 1'b0;
    @(negedge clk);
    chk("rstw_req", {31'd0, mc_req}, 32'd0);
    chk("rstw_we", {31'd0, out_rd_write_enable}, 32'd0);
    chk("rstw_data", out_rd_data, 32'd0);
    clear_in();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_req_after", {31'd0, mc_req}, 32'd0);
    chk("rstw_stall_after", {31'd0, stall_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Combinational/sequential MEM stage between EX_MEM and MEM_WB pipeline registers of the 5-stage RV32I core.
- Consumes the EX_MEM outputs and issues at most one load/store request per instruction to the memory controller (req/done handshake).
- Stalls the pipeline while the access is outstanding, then sign/zero-extends load data and drives rd data/address/enable into MEM_WB and the ID forwarding path.

Parameters:
- ADDR_LEN, 32, address width
- REG_LEN, 32, register/data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; low = pipeline paused
- in_wr_enable  in  1  instruction performs memory access (from EX_MEM)
- in_wr  in  1  0 = Read (load), 1 = Write (store)
- in_funct3  in  3  load/store funct3
- in_type  in  2  access size: 00 byte, 01 half, 10 word
- in_addr  in  ADDR_LEN  load/store byte address
- in_store_data  in  REG_LEN  store data, right-aligned
- in_rd_addr  in  5  destination register
- in_rd_write_enable  in  1  rd write enable
- in_rd_data  in  REG_LEN  ALU result for non-loads
- mc_req  out  1  request to memory controller, level, held until mc_done
- mc_wr  out  1  request direction
- mc_type  out  2  request size
- mc_addr  out  ADDR_LEN  request address
- mc_wdata  out  REG_LEN  store data
- mc_done  in  1  one-cycle pulse; access complete
- mc_rdata  in  REG_LEN  load data, right-aligned, valid with mc_done
- out_rd_data  out  REG_LEN  to MEM_WB and ID forwarding
- out_rd_addr  out  5  to MEM_WB and ID forwarding
- out_rd_write_enable  out  1  to MEM_WB and ID forwarding
- stall_req  out  1  to stall controller; freezes IF..EX_MEM

Behaviour:
- Reset (rst = 0 at posedge):
  - state = IDLE; mc_req = 0; load_data_reg = 0.
  - All combinational outputs then evaluate to 0 given reset-valued EX_MEM inputs.
  - Reset wins over mc_done in the same cycle.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - No access (in_wr_enable = 0): stall_req = 0; outputs pass through in_rd_*; zero latency.
  - Access and rdy = 1: stall_req = 1 combinationally in the same cycle.
  - On the next edge: state <- WAIT; mc_req <- 1. mc_wr/mc_type/mc_addr/mc_wdata are registered from in_* at that edge.
- WAIT:
  - stall_req = 1; mc_req = 1; request fields held stable.
  - On mc_done: state <- DONE; mc_req <- 0; load_data_reg <- extended mc_rdata.
  - The mc_done transition does not depend on rdy, so the pulse is never lost.
- DONE:
  - stall_req = 0, so the pipeline advances at this edge when rdy = 1.
  - rdy = 1: state <- IDLE. rdy = 0: hold DONE.
  - Guarantees exactly one request per instruction; the next instruction is sampled in IDLE.
- Output mux:
  - Load in DONE: out_rd_data = load_data_reg; rd_addr/write_enable from in_*.
  - Load in IDLE/WAIT: out_rd_write_enable = 0; out_rd_data = 0.
  - Store: in_rd_* passthrough (EX already clears the write enable).
  - Non-memory: in_rd_* passthrough.
- Load extension by funct3:
  - 000 LB: sign-extend bit 7
  - 001 LH: sign-extend bit 15
  - 010 LW: unchanged
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - Other codes: 0.
- mc_done outside WAIT: ignored.
- Reset mid-WAIT: mc_req drops next cycle. The memory controller aborts on req deassertion; no data is written back.
- rdy = 0 in IDLE: no transition; stall_req still asserted for a pending access.
- Back-to-back accesses: one idle bubble (DONE->IDLE), then a new request. Minimum access = 3 cycles of MEM occupancy plus memctrl latency.

Decomposition:
- Shared defines header, not this block: Read/Write, Enable/Disable, ZERO_WORD, X0, funct3 codes for LB/LH/LW/LBU/LHU, AddrLen/RegLen/RegAddrLen.
- Local constants: state encoding (2 bits).
- One natural sub-module: load_extend (combinational funct3-driven sign/zero extension), reusable by memctrl tests.

Test Plan:
- LB from 0x100, memctrl returns 0x00000080 after 4 cycles: mc_req high 4 cycles, one request with mc_type = 00, mc_wr = 0; out_rd_data = 0xFFFFFF80 in DONE; stall_req drops same cycle.
- LBU same data -> 0x00000080; LH with 0x00008001 -> 0xFFFF8001; LHU -> 0x00008001; LW 0xDEADBEEF -> unchanged.
- SW addr 0x1000 data 0x12345678: mc_wr = 1, mc_addr = 0x1000, mc_wdata = 0x12345678, mc_type = 10; out_rd_write_enable = 0.
- ADD result 0x55 to x5, no access: stall_req never asserts; outputs = 0x55/x5/1 the same cycle.
- Two consecutive loads held by stall: exactly two mc_req rising edges. rdy = 0 during DONE holds DONE and does not re-issue.
- rst = 0 during WAIT with simultaneous mc_done: state IDLE, mc_req = 0, out_rd_write_enable = 0 next cycle.
